// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter between instruction-fetch and data ports onto one memory
module mem_arbiter #(
  parameter int DATA_L  = 8,
  parameter int MADDR_L = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [MADDR_L-1:0] i_addr,
  output logic               i_ack,
  output logic [DATA_L-1:0]  i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [MADDR_L-1:0] d_addr,
  input  logic [DATA_L-1:0]  d_wdata,
  output logic               d_ack,
  output logic [DATA_L-1:0]  d_rdata,
  input  logic [DATA_L-1:0]  m_din,
  output logic [DATA_L-1:0]  m_dout,
  output logic [MADDR_L-1:0] m_raddr,
  output logic [MADDR_L-1:0] m_waddr,
  output logic               m_re,
  output logic               m_we
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic               rr_d;        // 1 = data port won the last grant
  logic               gnt_d;
  logic               we_q;
  logic [MADDR_L-1:0] addr_q;
  logic [DATA_L-1:0]  wdata_q;
  logic [DATA_L-1:0]  rdata_q;
  logic [CW-1:0]      cnt;
  logic               grant;
  logic               pick_d;
  logic               last_read;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    last_read = 1'b0;
    pick_d    = d_req && !(i_req && rr_d);
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_nxt = RESP;
        end else if (cnt == '0) begin
          last_read = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_d    <= 1'b0;
      gnt_d   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (grant) begin
        gnt_d  <= pick_d;
        rr_d   <= pick_d;
        we_q   <= pick_d && d_we;
        addr_q <= pick_d ? d_addr : i_addr;
        if (pick_d) wdata_q <= d_wdata;
        cnt    <= CW'(MEM_LAT - 1);
      end else if (state == ACCESS && !we_q && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (last_read) rdata_q <= m_din;
    end
  end

  assign m_re    = (state == ACCESS) && !we_q;
  assign m_we    = (state == ACCESS) && we_q;
  assign m_raddr = addr_q;
  assign m_waddr = addr_q;
  assign m_dout  = wdata_q;
  assign i_ack   = (state == RESP) && !gnt_d;
  assign d_ack   = (state == RESP) && gnt_d;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  d_wdata;
  logic        i_ack, d_ack, m_re, m_we;
  logic [7:0]  i_rdata, d_rdata, m_din, m_dout;
  logic [31:0] m_raddr, m_waddr;

  logic        rst1, i1_req;
  logic [31:0] i1_addr;
  logic        i1_ack, d1_ack, m1_re, m1_we;
  logic [7:0]  i1_rdata, d1_rdata, m1_dout;
  logic [31:0] m1_raddr, m1_waddr;
  logic [7:0]  m1_din;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_L(8), .MADDR_L(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_din(m_din), .m_dout(m_dout), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_re(m_re), .m_we(m_we)
  );

  mem_arbiter #(.DATA_L(8), .MADDR_L(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(8'h0),
    .d_ack(d1_ack), .d_rdata(d1_rdata),
    .m_din(m1_din), .m_dout(m1_dout), .m_raddr(m1_raddr), .m_waddr(m1_waddr),
    .m_re(m1_re), .m_we(m1_we)
  );

  // Memory environment: data is only valid on the LAT-th cycle of a read burst.
  logic [7:0] env_mem [16];
  int         re_cnt = 0;

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    re_cnt <= m_re ? re_cnt + 1 : 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
    end else if (m_we) begin
      env_mem[m_waddr[3:0]] <= m_dout;
    end
  end

  assign m_din  = (m_re && re_cnt == LAT - 1) ? env_mem[m_raddr[3:0]] : ~env_mem[m_raddr[3:0]];
  assign m1_din = m1_re ? 8'h3C : 8'hC3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference model
  bit          active, mdl_gd, mdl_we, last_d;
  int          t0, ack_c;
  logic [31:0] mdl_addr;
  logic [7:0]  mdl_data, exp_val, mdl_rdata;
  logic [7:0]  mdl_mem [16];
  bit          exp_re, exp_we, exp_ack;

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    rst1 = 1'b1; i1_req = 0; i1_addr = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_m_raddr", m_raddr, 0);
    check_eq("reset_m_dout", m_dout, 0);
    check_eq("reset_m_re_we", {m_re, m_we}, 0);
    active = 0; last_d = 0; mdl_rdata = 0; t0 = 0; ack_c = -1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);

    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      else rst = 1'b0;
      if (c == 0) @(negedge clk);
      ack_c   = active ? (mdl_we ? t0 + 2 : t0 + LAT + 1) : -1;
      exp_re  = active && !mdl_we && c >= t0 + 1 && c <= t0 + LAT;
      exp_we  = active && mdl_we && c == t0 + 1;
      exp_ack = active && c == ack_c;
      if (exp_ack && !mdl_we) mdl_rdata = exp_val;
      check_eq("i_ack", i_ack, exp_ack && !mdl_gd);
      check_eq("d_ack", d_ack, exp_ack && mdl_gd);
      check_eq("m_re", m_re, exp_re);
      check_eq("m_we", m_we, exp_we);
      check_eq("i_rdata", i_rdata, mdl_rdata);
      check_eq("d_rdata", d_rdata, mdl_rdata);
      if (exp_re) check_eq("m_raddr", m_raddr, mdl_addr);
      if (exp_we) begin
        check_eq("m_waddr", m_waddr, mdl_addr);
        check_eq("m_dout", m_dout, mdl_data);
      end

      rst = (c >= 60) && ($urandom_range(0, 99) < 3);
      if (c < 40) begin
        i_req = 1; d_req = 1;
      end else begin
        i_req = ($urandom_range(0, 9) < 6);
        d_req = ($urandom_range(0, 9) < 6);
      end
      d_we    = $urandom_range(0, 1);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = 8'($urandom);

      if (rst) begin
        active = 0; last_d = 0; mdl_rdata = 0;
        for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);
      end else if ((!active || c > ack_c) && (i_req || d_req)) begin
        mdl_gd   = d_req && !(i_req && last_d);
        last_d   = mdl_gd;
        mdl_we   = mdl_gd && d_we;
        mdl_addr = mdl_gd ? d_addr : i_addr;
        mdl_data = d_wdata;
        t0       = c;
        active   = 1;
        if (mdl_we) mdl_mem[mdl_addr[3:0]] = mdl_data;
        else        exp_val = mdl_mem[mdl_addr[3:0]];
      end
    end
    rst = 1'b0; i_req = 0; d_req = 0;

    // MEM_LAT=1 instance: one-cycle read strobe and ack two cycles after the request
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    i1_req = 1; i1_addr = 32'h0000_0100;
    @(negedge clk);
    i1_req = 0;
    check_eq("lat1_re_t1", m1_re, 1);
    check_eq("lat1_raddr_t1", m1_raddr, 32'h100);
    check_eq("lat1_ack_t1", i1_ack, 0);
    @(negedge clk);
    check_eq("lat1_re_t2", m1_re, 0);
    check_eq("lat1_ack_t2", i1_ack, 1);
    check_eq("lat1_rdata_t2", i1_rdata, 8'h3C);
    @(negedge clk);
    check_eq("lat1_ack_t3", i1_ack, 0);
    check_eq("lat1_d_ack", d1_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_L, default 8, meaning data width of the requester and memory data buses.
REQ-002 The block SHALL have parameter MADDR_L, default 32, meaning address width.
REQ-003 The block SHALL have parameter MEM_LAT, default 2, meaning cycles from m_re assertion to m_din valid; legal range is MEM_LAT >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_req, input, 1 bit: instruction-fetch read request.
REQ-007 The block SHALL have port i_addr, input, MADDR_L bits: fetch address.
REQ-008 The block SHALL have port i_ack, output, 1 bit: one-cycle fetch completion pulse.
REQ-009 The block SHALL have port i_rdata, output, DATA_L bits: fetch read data, valid while i_ack is high.
REQ-010 The block SHALL have port d_req, input, 1 bit: data-port request.
REQ-011 The block SHALL have port d_we, input, 1 bit: data-port write enable (1 = write, 0 = read).
REQ-012 The block SHALL have port d_addr, input, MADDR_L bits: data-port address.
REQ-013 The block SHALL have port d_wdata, input, DATA_L bits: data-port write data.
REQ-014 The block SHALL have port d_ack, output, 1 bit: one-cycle data-port completion pulse.
REQ-015 The block SHALL have port d_rdata, output, DATA_L bits: data-port read data, valid while d_ack is high.
REQ-016 The block SHALL have memory-side ports m_din (input, DATA_L), m_dout (output, DATA_L), m_raddr (output, MADDR_L), m_waddr (output, MADDR_L), m_re (output, 1) and m_we (output, 1).

Function
REQ-017 The block SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-018 In IDLE with exactly one request high, that requester SHALL be granted; its address, d_we and d_wdata SHALL be latched, and the FSM SHALL enter ACCESS.
REQ-019 In IDLE with both requests high, the block SHALL grant the requester that was not granted last (round-robin pointer), then update the pointer to the winner.
REQ-020 A read in ACCESS SHALL hold m_re=1 with m_raddr set to the latched address for exactly MEM_LAT cycles, counted by a down-counter.
REQ-021 In the last ACCESS cycle of a read, the block SHALL capture m_din into the read-data register and enter RESP.
REQ-022 A write in ACCESS SHALL assert m_we=1 for exactly one cycle, with m_waddr set to the latched address and m_dout set to the latched data, then enter RESP.
REQ-023 In RESP, the block SHALL assert the granted port's ack for exactly one cycle and return to IDLE.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle T; read ack at T+MEM_LAT+1; write ack at T+2.
REQ-025 i_rdata and d_rdata SHALL both be driven from the shared read-data register, which holds its value until the next read capture.
REQ-026 The block SHALL never assert m_re and m_we in the same cycle, and SHALL hold both at 0 outside ACCESS.
REQ-027 m_raddr, m_waddr and m_dout SHALL hold their last latched values when idle.
REQ-028 Request inputs SHALL be sampled only in IDLE; deasserting a request during ACCESS or RESP SHALL NOT abort the access, and its ack SHALL still be issued.
REQ-029 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-030 i_ack and d_ack SHALL never be high in the same cycle.
REQ-031 Requests that arrive during ACCESS or RESP SHALL wait, unacknowledged, until IDLE.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL enter IDLE and drive i_ack, d_ack, m_re and m_we to 0.
REQ-033 On reset, the address, write-data and read-data registers and the latency counter SHALL be cleared to 0.
REQ-034 On reset, the round-robin pointer SHALL be set to "instruction last granted", so the first tie goes to the data port.
REQ-035 A reset during ACCESS or RESP SHALL abort the transaction with no ack issued.

Verification
REQ-036 With MEM_LAT=2, an i_req to 0x100 while memory returns 0x5A -> m_re=1 with m_raddr=0x100 at T+1 and T+2; i_ack=1 and i_rdata=0x5A at T+3 only.
REQ-037 A d write to 0x20 with data 0xC3 -> at T+1 only: m_we=1, m_waddr=0x20, m_dout=0xC3; m_re=0 throughout; d_ack=1 at T+2.
REQ-038 i_req and d_req held high continuously after reset -> grant order D, I, D, I; no cycle has both acks high.
REQ-039 d read with d_req dropped at T+1 -> exactly one d_ack at T+MEM_LAT+1 and no second access.
REQ-040 rst pulsed during a read ACCESS -> next cycle m_re=0, no ack, FSM in IDLE; a following i_req completes with normal latency.
REQ-041 With MEM_LAT=1, a read -> m_re high for one cycle (T+1) and ack at T+2.
